// File: rtl/commit_trace_checker_pkg.sv
// Shared types for the commit trace checker: golden/commit event encoding and checker FSM states.
package commit_trace_checker_pkg;

  localparam int unsigned TRACE_ADDR_W = 16;
  localparam int unsigned TRACE_DATA_W = 32;

  typedef enum logic [1:0] {
    TK_REG  = 2'd0,
    TK_MEM  = 2'd1,
    TK_SKIP = 2'd2,
    TK_RSVD = 2'd3
  } trace_kind_t;

  // Event layout is {kind, addr, data}, matching the flat err_got/err_exp ports.
  typedef struct packed {
    trace_kind_t               kind;
    logic [TRACE_ADDR_W-1:0]   addr;
    logic [TRACE_DATA_W-1:0]   data;
  } trace_event_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ERROR = 2'd1,
    ST_DONE  = 2'd2
  } chk_state_t;

endpackage

// File: rtl/commit_trace_checker_event_fifo.sv
// Circular event buffer: up to NPUSH compacted pushes and one pop per cycle, with free-slot report.
module commit_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 50,
  parameter int unsigned NPUSH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(NPUSH+1)-1:0]   push_cnt,
  input  logic [NPUSH-1:0][W-1:0]      push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head_c,
  output logic                         empty_c,
  output logic [$clog2(DEPTH+1)-1:0]   free_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned PC_W  = $clog2(NPUSH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NPUSH); i++) begin
      if (PC_W'(i) < push_cnt) mem[wr_ptr + PTR_W'(i)] <= push_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count + CNT_W'(push_cnt) - CNT_W'(pop);
    end
  end

  assign head_c  = mem[rd_ptr];
  assign empty_c = (count == '0);
  assign free_c  = CNT_W'(DEPTH) - count;

endmodule

// File: rtl/commit_trace_checker.sv
// Commit-stream checker: serialises per-lane side effects and compares them against a golden trace.
module commit_trace_checker
  import commit_trace_checker_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned ADDR_W       = TRACE_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COMMIT_WIDTH-1:0]      reg_we,
  input  logic [COMMIT_WIDTH*5-1:0]    reg_waddr,
  input  logic [COMMIT_WIDTH*32-1:0]   reg_wdata,
  input  logic [COMMIT_WIDTH-1:0]      st_valid,
  input  logic [COMMIT_WIDTH*32-1:0]   st_paddr,
  input  logic [COMMIT_WIDTH*32-1:0]   st_wrdata,
  input  logic                         exp_valid,
  output logic                         exp_ready,
  input  logic [1:0]                   exp_kind,
  input  logic [ADDR_W-1:0]            exp_addr,
  input  logic [31:0]                  exp_data,
  input  logic                         exp_last,
  output logic                         done,
  output logic [1:0]                   err_code,
  output logic [31:0]                  err_cycle,
  output logic [2+ADDR_W+32-1:0]       err_got,
  output logic [2+ADDR_W+32-1:0]       err_exp,
  output logic [31:0]                  checked
);

  localparam int unsigned EV_W  = 2 + ADDR_W + 32;
  localparam int unsigned NPUSH = 2 * COMMIT_WIDTH;
  localparam int unsigned PC_W  = $clog2(NPUSH+1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

  chk_state_t state;
  chk_state_t state_nxt;

  logic [NPUSH-1:0][EV_W-1:0] raw_ev;
  logic [NPUSH-1:0]           raw_vld;
  logic [NPUSH-1:0][EV_W-1:0] evt_vec;
  logic [PC_W-1:0]            evt_cnt;
  logic [PC_W-1:0]            push_cnt;
  logic [EV_W-1:0]            head;
  logic [EV_W-1:0]            exp_event;
  logic                       fifo_empty;
  logic [CNT_W-1:0]           fifo_free;
  logic                       pop;
  logic                       match;
  logic                       over;
  logic [31:0]                cyc;
  logic                       unused_paddr;

  assign unused_paddr = ^st_paddr;
  assign exp_event    = {exp_kind, exp_addr, exp_data};

  // Per-lane events in program order: lane i REG at slot 2i, MEM at slot 2i+1.
  always_comb begin
    raw_ev  = '0;
    raw_vld = '0;
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      raw_vld[2*i]   = reg_we[i] && (reg_waddr[i*5 +: 5] != 5'd0);
      raw_ev[2*i]    = {TK_REG, ADDR_W'(reg_waddr[i*5 +: 5]), reg_wdata[i*32 +: 32]};
      raw_vld[2*i+1] = st_valid[i];
      raw_ev[2*i+1]  = {TK_MEM, st_paddr[i*32 +: ADDR_W], st_wrdata[i*32 +: 32]};
    end
  end

  // Compaction by walking events backwards and shifting each valid one in at slot 0.
  always_comb begin
    evt_vec = '0;
    evt_cnt = '0;
    for (int k = int'(NPUSH) - 1; k >= 0; k--) begin
      if (raw_vld[k]) begin
        if (NPUSH > 1) evt_vec = {evt_vec[NPUSH-2:0], raw_ev[k]};
        else           evt_vec = raw_ev[k];
      end
      evt_cnt = evt_cnt + PC_W'(raw_vld[k]);
    end
  end

  always_comb begin
    match    = (exp_kind == TK_SKIP) || (head == exp_event);
    over     = (state == ST_RUN) && (32'(evt_cnt) > (32'(fifo_free) + 32'(pop)));
    push_cnt = ((state == ST_RUN) && !over) ? evt_cnt : '0;
  end

  commit_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EV_W),
    .NPUSH (NPUSH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_cnt  (push_cnt),
    .push_data (evt_vec),
    .pop       (pop),
    .head_c    (head),
    .empty_c   (fifo_empty),
    .free_c    (fifo_free)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // A pop mismatch outranks a same-cycle overflow; ERROR and DONE hold until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (pop && !match)          state_nxt = ST_ERROR;
        else if (over)              state_nxt = ST_ERROR;
        else if (pop && exp_last)   state_nxt = ST_DONE;
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    exp_ready = 1'b0;
    if (state == ST_RUN) begin
      pop       = !fifo_empty && exp_valid;
      exp_ready = pop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc       <= '0;
      checked   <= '0;
      done      <= 1'b0;
      err_code  <= 2'd0;
      err_cycle <= '0;
      err_got   <= '0;
      err_exp   <= '0;
    end else if (state == ST_RUN) begin
      if (cyc != 32'hFFFF_FFFF) cyc <= cyc + 32'd1;
      if (pop && match) checked <= checked + 32'd1;
      if (pop && !match) begin
        err_code  <= 2'd1;
        err_cycle <= cyc;
        err_got   <= head;
        err_exp   <= exp_event;
      end else if (over) begin
        err_code  <= 2'd2;
        err_cycle <= cyc;
        err_got   <= evt_vec[0];
        err_exp   <= '0;
      end else if (pop && exp_last) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Self-checking bench: directed and random commit streams against a queue-based trace model.
module tb_commit_trace_checker;

  localparam int CW    = 2;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [CW-1:0]   reg_we;
  logic [CW*5-1:0] reg_waddr;
  logic [CW*32-1:0] reg_wdata;
  logic [CW-1:0]   st_valid;
  logic [CW*32-1:0] st_paddr;
  logic [CW*32-1:0] st_wrdata;
  logic            exp_valid;
  logic            exp_ready;
  logic [1:0]      exp_kind;
  logic [15:0]     exp_addr;
  logic [31:0]     exp_data;
  logic            exp_last;
  logic            done;
  logic [1:0]      err_code;
  logic [31:0]     err_cycle;
  logic [49:0]     err_got;
  logic [49:0]     err_exp;
  logic [31:0]     checked;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [49:0] mq[$];
  int          mstate;
  logic [31:0] mcyc, mchk, mecyc;
  logic [1:0]  mec;
  logic [49:0] mgot, mexp;
  logic        mdone;

  always #5 clk = ~clk;

  commit_trace_checker #(.COMMIT_WIDTH(CW), .FIFO_DEPTH(DEPTH), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .st_valid(st_valid), .st_paddr(st_paddr), .st_wrdata(st_wrdata),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_last(exp_last),
    .done(done), .err_code(err_code), .err_cycle(err_cycle),
    .err_got(err_got), .err_exp(err_exp), .checked(checked)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reg_we = '0; reg_waddr = '0; reg_wdata = '0;
    st_valid = '0; st_paddr = '0; st_wrdata = '0;
    exp_valid = 1'b0; exp_kind = 2'd0; exp_addr = '0; exp_data = '0; exp_last = 1'b0;
  endtask

  task automatic set_reg(input int lane, input int a, input logic [31:0] d);
    reg_we[lane] = 1'b1;
    reg_waddr[lane*5 +: 5] = 5'(a);
    reg_wdata[lane*32 +: 32] = d;
  endtask

  task automatic set_st(input int lane, input logic [31:0] a, input logic [31:0] d);
    st_valid[lane] = 1'b1;
    st_paddr[lane*32 +: 32] = a;
    st_wrdata[lane*32 +: 32] = d;
  endtask

  task automatic gold(input logic [1:0] k, input logic [15:0] a, input logic [31:0] d, input logic l);
    exp_valid = 1'b1; exp_kind = k; exp_addr = a; exp_data = d; exp_last = l;
  endtask

  // Present the model's next expected event; optionally replace stores with SKIP entries.
  task automatic gold_q(input logic l, input bit skip_mem);
    logic [49:0] e;
    if (mq.size() > 0) begin
      e = mq[0];
      if (skip_mem && e[49:48] == 2'd1) gold(2'd2, 16'($urandom), $urandom, l);
      else gold(e[49:48], e[47:32], e[31:0], l);
    end else begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_exp_ready", 64'(exp_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_err_cycle", 64'(err_cycle), 64'd0);
    chk("rst_err_got", 64'(err_got), 64'd0);
    chk("rst_err_exp", 64'(err_exp), 64'd0);
    chk("rst_checked", 64'(checked), 64'd0);
    mq = {}; mstate = 0; mcyc = 0; mchk = 0; mecyc = 0; mec = 0;
    mgot = 0; mexp = 0; mdone = 0;
    #1 rst = 1'b1;
  endtask

  // One clock: check exp_ready before the edge, advance the model, check registered outputs after.
  task automatic cycle();
    logic [49:0] evs[$];
    logic [49:0] g, h;
    bit pop, match, over;
    int nocc;
    g = {exp_kind, exp_addr, exp_data};
    h = '0;
    evs = {};
    for (int i = 0; i < CW; i++) begin
      if (reg_we[i] && reg_waddr[i*5 +: 5] != 5'd0)
        evs.push_back({2'd0, 16'(reg_waddr[i*5 +: 5]), reg_wdata[i*32 +: 32]});
      if (st_valid[i])
        evs.push_back({2'd1, st_paddr[i*32 +: 16], st_wrdata[i*32 +: 32]});
    end
    pop = (mstate == 0) && (mq.size() > 0) && exp_valid;
    #1;
    chk("exp_ready", 64'(exp_ready), 64'(pop));
    @(posedge clk);
    if (mstate == 0) begin
      nocc = mq.size() - (pop ? 1 : 0) + evs.size();
      over = nocc > DEPTH;
      match = 1'b0;
      if (pop) begin
        h = mq.pop_front();
        match = (exp_kind == 2'd2) || (h == g);
      end
      if (!over) foreach (evs[j]) mq.push_back(evs[j]);
      if (pop && match) mchk++;
      if (pop && !match) begin
        mstate = 1; mec = 1; mecyc = mcyc; mgot = h; mexp = g;
      end else if (over) begin
        mstate = 1; mec = 2; mecyc = mcyc; mgot = evs[0];
      end else if (pop && exp_last) begin
        mstate = 2; mdone = 1;
      end
      if (mcyc != 32'hFFFF_FFFF) mcyc++;
    end
    #1;
    chk("done", 64'(done), 64'(mdone));
    chk("err_code", 64'(err_code), 64'(mec));
    chk("err_cycle", 64'(err_cycle), 64'(mecyc));
    chk("err_got", 64'(err_got), 64'(mgot));
    if (mec != 2'd2) chk("err_exp", 64'(err_exp), 64'(mexp));
    chk("checked", 64'(checked), 64'(mchk));
  endtask

  task automatic push_four(input int base);
    set_reg(0, base, 32'h1000 + 32'(base));
    set_st(0, 32'h8000_0000 + 32'(base), 32'hA000 + 32'(base));
    set_reg(1, base + 1, 32'h2000 + 32'(base));
    set_st(1, 32'h0000_0100 + 32'(base), 32'hB000 + 32'(base));
  endtask

  task automatic drain(input logic last_on_final);
    for (int n = 0; n < 20 && mq.size() > 0; n++) begin
      idle();
      gold_q(last_on_final && mq.size() == 1, 1'b1);
      cycle();
    end
  endtask

  initial begin
    idle();
    do_reset();

    // Fill to full, then a same-cycle pop+push at full occupancy, then drain with wrap.
    idle(); push_four(1); cycle();
    idle(); push_four(10); cycle();
    idle(); set_reg(1, 20, 32'h0000_2020); gold_q(1'b0, 1'b0); cycle();
    chk("full_pushpop_no_err", 64'(err_code), 64'd0);
    drain(1'b0);
    chk("drain_checked", 64'(checked), 64'd9);

    // SKIP against a store then a REG match, past the pointer wrap.
    idle(); set_st(0, 32'h0000_0040, 32'h1111_2222); set_reg(1, 7, 32'h77); cycle();
    idle(); gold(2'd2, 16'h5555, 32'h0, 1'b0); cycle();
    idle(); gold(2'd0, 16'd7, 32'h77, 1'b0); cycle();
    chk("skip_wrap_checked", 64'(checked), 64'd11);

    // Random matching traffic with SKIPs and gaps in golden validity.
    for (int c = 0; c < 300; c++) begin
      idle();
      if (mq.size() <= DEPTH - 4) begin
        for (int l = 0; l < CW; l++) begin
          if ($urandom_range(0, 1) == 1) set_reg(l, int'($urandom_range(0, 31)), $urandom);
          if ($urandom_range(0, 2) == 0) set_st(l, $urandom, $urandom);
        end
      end
      if ($urandom_range(0, 3) != 0) begin
        if (mq.size() > 0) gold_q(1'b0, $urandom_range(0, 4) == 0);
        else gold(2'($urandom), 16'($urandom), $urandom, 1'b0);
      end
      cycle();
    end
    idle(); set_reg(0, 9, 32'h0000_0999); cycle();
    drain(1'b1);
    chk("random_done", 64'(done), 64'd1);
    idle(); set_reg(0, 3, 32'h3); gold(2'd0, 16'd3, 32'h3, 1'b0); cycle();

    // Single REG with last.
    do_reset();
    idle(); set_reg(0, 3, 32'h0000_1234); gold(2'd0, 16'd3, 32'h1234, 1'b1); cycle();
    idle(); gold(2'd0, 16'd3, 32'h1234, 1'b1); cycle();
    chk("t1_checked", 64'(checked), 64'd1);
    chk("t1_done", 64'(done), 64'd1);

    // $0 write is dropped; lane1 REG precedes lane1 MEM.
    do_reset();
    idle(); set_reg(0, 0, 32'hCAFE); set_reg(1, 5, 32'hFF); set_st(1, 32'h0000_0040, 32'hDEAD_BEEF); cycle();
    idle(); gold(2'd0, 16'd5, 32'hFF, 1'b0); cycle();
    idle(); gold(2'd1, 16'h0040, 32'hDEAD_BEEF, 1'b0); cycle();
    chk("t2_checked", 64'(checked), 64'd2);

    // Data mismatch detected with the counter at 37.
    do_reset();
    for (int c = 0; c < 36; c++) begin idle(); cycle(); end
    idle(); set_reg(0, 5, 32'h2); gold(2'd0, 16'd5, 32'h1, 1'b0); cycle();
    idle(); gold(2'd0, 16'd5, 32'h1, 1'b0); cycle();
    chk("t3_err_code", 64'(err_code), 64'd1);
    chk("t3_err_cycle", 64'(err_cycle), 64'd37);
    chk("t3_err_got", 64'(err_got), {14'd0, 2'd0, 16'd5, 32'h2});
    for (int c = 0; c < 3; c++) begin idle(); set_reg(0, 5, 32'h1); gold(2'd0, 16'd5, 32'h1, 1'b0); cycle(); end

    // Reserved kind never matches.
    do_reset();
    idle(); set_reg(0, 6, 32'h66); cycle();
    idle(); gold(2'd3, 16'd6, 32'h66, 1'b0); cycle();
    chk("rsvd_err_code", 64'(err_code), 64'd1);

    // Overflow: nine events with no golden.
    do_reset();
    idle(); push_four(1); cycle();
    idle(); push_four(11); cycle();
    idle(); set_reg(0, 4, 32'h0444); cycle();
    chk("ovf_err_code", 64'(err_code), 64'd2);
    chk("ovf_checked", 64'(checked), 64'd0);
    chk("ovf_err_got", 64'(err_got), {14'd0, 2'd0, 16'd4, 32'h0444});
    idle(); push_four(2); gold(2'd0, 16'd1, 32'h1001, 1'b0); cycle();

    // Reset during ERROR, then checking resumes.
    do_reset();
    idle(); set_reg(1, 3, 32'h0000_1234); gold(2'd0, 16'd3, 32'h1234, 1'b1); cycle();
    idle(); gold(2'd0, 16'd3, 32'h1234, 1'b1); cycle();
    chk("resume_checked", 64'(checked), 64'd1);
    chk("resume_done", 64'(done), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
